// File: rtl/kudelski_ro_meas_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kudelski_ro_meas_ctrl_if                                |
// | Description : Bundle of request, RO and result signals between the    |
// |               RO measurement controller and its requester/RO wrapper. |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface kudelski_ro_meas_ctrl_if #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
);
  localparam int SEL_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  logic              i_start;
  logic              i_abort;
  logic [SEL_W-1:0]  i_sel;
  logic [WIN_W-1:0]  i_win_len;
  logic              o_busy;
  logic              o_ro_en;
  logic [N_BITS-1:0] i_ro_clk;
  logic              o_cnt_valid;
  logic              i_cnt_ready;
  logic [CNT_W-1:0]  o_cnt;
  logic              o_cnt_sat;

  // Requester / RO wrapper side
  modport master (
    output i_start, i_abort, i_sel, i_win_len, i_ro_clk, i_cnt_ready,
    input  o_busy, o_ro_en, o_cnt_valid, o_cnt, o_cnt_sat
  );

  // Controller side
  modport slave (
    input  i_start, i_abort, i_sel, i_win_len, i_ro_clk, i_cnt_ready,
    output o_busy, o_ro_en, o_cnt_valid, o_cnt, o_cnt_sat
  );
endinterface
`default_nettype wire

// File: rtl/kudelski_ro_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kudelski_ro_meas_ctrl                                   |
// | Description : Enables the RO array, selects one RO bit, counts its    |
// |               rising edges over a programmable window and returns     |
// |               the count on a valid/ready result port.                 |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module kudelski_ro_meas_ctrl #(
  parameter int N_BITS        = 8,
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input wire logic               i_clk,
  input wire logic               i_rst_n,
  kudelski_ro_meas_ctrl_if.slave bus
);
  localparam int SEL_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [WIN_W-1:0]  r_win_rem;
  logic [ST_W-1:0]   r_settle;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;
  logic              r_busy;
  logic              r_ro_en;
  logic              r_valid;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;

  logic [SEL_W-1:0]  w_sel_in;
  logic              w_ro_bit;
  logic              w_edge;

  // Out-of-range selects fall back to bit 0 so the mux index is always legal
  assign w_sel_in = (int'(bus.i_sel) < N_BITS) ? bus.i_sel : '0;
  assign w_ro_bit = bus.i_ro_clk[r_sel];
  assign w_edge   = r_sync2 & ~r_prev;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= w_ro_bit;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Measurement sequencer with registered status/result outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_win_rem <= '0;
      r_settle  <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_busy    <= 1'b0;
      r_ro_en   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (r_state != ST_IDLE && bus.i_abort) begin
      // Abort wins over every other transition; count is left as-is
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_ro_en <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            r_sel     <= w_sel_in;
            r_win_rem <= bus.i_win_len;
            r_settle  <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_busy    <= 1'b1;
            r_ro_en   <= 1'b1;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == ST_W'(SETTLE_CYCLES - 1)) begin
            if (r_win_rem == '0) begin
              r_ro_en <= 1'b0;
              r_valid <= 1'b1;
              r_state <= ST_RESULT;
            end else begin
              r_state <= ST_MEASURE;
            end
          end else begin
            r_settle <= r_settle + ST_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            if (r_cnt == '1) begin
              r_sat <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (r_win_rem == WIN_W'(1)) begin
            r_ro_en <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_RESULT;
          end else begin
            r_win_rem <= r_win_rem - WIN_W'(1);
          end
        end
        ST_RESULT: begin
          if (bus.i_cnt_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ro_en <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_ro_en     = r_ro_en;
  assign bus.o_cnt_valid = r_valid;
  assign bus.o_cnt       = r_cnt;
  assign bus.o_cnt_sat   = r_sat;

  // Result must not move while the consumer is stalling
  a_cnt_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_valid && !bus.i_cnt_ready) |=> ($stable(r_cnt) && $stable(r_sat)));

  // RO array is never enabled outside settle/measure
  a_ro_en_off : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == ST_IDLE || r_state == ST_RESULT) |-> !r_ro_en);

endmodule
`default_nettype wire

// File: tb/tb_kudelski_ro_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_kudelski_ro_meas_ctrl                                |
// | Description : Self-checking bench for kudelski_ro_meas_ctrl; drives   |
// |               a 16-bit and a 4-bit counter instance in lockstep.      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_kudelski_ro_meas_ctrl;
  localparam int N_BITS = 8;
  localparam int CNT_W  = 16;
  localparam int CNT4_W = 4;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 4;
  localparam int SEL_W  = $clog2(N_BITS);

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  kudelski_ro_meas_ctrl_if #(.N_BITS(N_BITS), .CNT_W(CNT_W),  .WIN_W(WIN_W)) bus ();
  kudelski_ro_meas_ctrl_if #(.N_BITS(N_BITS), .CNT_W(CNT4_W), .WIN_W(WIN_W)) bus4 ();

  // Narrow-counter instance sees exactly the same stimulus
  assign bus4.i_start     = bus.i_start;
  assign bus4.i_abort     = bus.i_abort;
  assign bus4.i_sel       = bus.i_sel;
  assign bus4.i_win_len   = bus.i_win_len;
  assign bus4.i_ro_clk    = bus.i_ro_clk;
  assign bus4.i_cnt_ready = bus.i_cnt_ready;

  kudelski_ro_meas_ctrl #(.N_BITS(N_BITS), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYCLES(SETTLE))
    u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  kudelski_ro_meas_ctrl #(.N_BITS(N_BITS), .CNT_W(CNT4_W), .WIN_W(WIN_W), .SETTLE_CYCLES(SETTLE))
    u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RO stimulus: 0 random, 1 period-4 on sel from first measure cycle, 2 all-zero
  function automatic logic [N_BITS-1:0] ro_val(input int mode, input int k, input int sel);
    logic [N_BITS-1:0] one;
    one = 1;
    case (mode)
      0:       return N_BITS'($urandom);
      1:       return (k >= 1 + SETTLE && ((k - 1 - SETTLE) % 4) < 2) ? (one << sel) : '0;
      default: return '0;
    endcase
  endfunction

  // One full measurement, checked against a rising-edge count over the window
  task automatic run_meas(input int sel, input int win, input int mode, input int rdy_dly);
    logic [N_BITS-1:0] hist[$];
    int lat;
    int rises;
    int exp16;
    int exp4;
    lat   = -1;
    rises = 0;
    bus.i_sel     = SEL_W'(sel);
    bus.i_win_len = WIN_W'(win);
    bus.i_start   = 1'b1;
    hist.push_back(ro_val(mode, 0, sel));
    bus.i_ro_clk = hist[0];
    for (int k = 1; k <= 1 + SETTLE + win + 4; k++) begin
      tick();
      if (k == 1) begin
        bus.i_start   = 1'b0;
        bus.i_sel     = SEL_W'($urandom);
        bus.i_win_len = WIN_W'($urandom);
      end
      if (bus.o_cnt_valid) begin
        lat = k;
        break;
      end
      check("busy_during_meas", bus.o_busy, 1);
      check("ro_en_during_meas", bus.o_ro_en, 1);
      hist.push_back(ro_val(mode, k, sel));
      bus.i_ro_clk = hist[k];
    end
    if (lat < 0) begin
      check("valid_timeout", 0, 1);
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      return;
    end
    // A rise first present in cycle c is seen by the edge detector two cycles later,
    // so only rises in cycles SETTLE-1 .. SETTLE+win-2 land inside the window.
    for (int c = SETTLE - 1; c <= SETTLE + win - 2; c++)
      if (c >= 1 && hist[c][sel] && !hist[c-1][sel]) rises++;
    exp16 = (rises > 65535) ? 65535 : rises;
    exp4  = (rises > 15) ? 15 : rises;
    check("latency", lat, 1 + SETTLE + win);
    check("cnt16", bus.o_cnt, exp16);
    check("sat16", bus.o_cnt_sat, (rises > 65535) ? 1 : 0);
    check("cnt4", bus4.o_cnt, exp4);
    check("sat4", bus4.o_cnt_sat, (rises > 15) ? 1 : 0);
    check("ro_en_result", bus.o_ro_en, 0);
    check("valid4", bus4.o_cnt_valid, 1);
    for (int d = 0; d < rdy_dly; d++) begin
      bus.i_ro_clk = N_BITS'($urandom);
      bus.i_start  = (d == 2);
      tick();
      check("bp_valid", bus.o_cnt_valid, 1);
      check("bp_cnt", bus.o_cnt, exp16);
      check("bp_busy", bus.o_busy, 1);
    end
    bus.i_start     = 1'b0;
    bus.i_cnt_ready = 1'b1;
    tick();
    bus.i_cnt_ready = 1'b0;
    check("post_hs_valid", bus.o_cnt_valid, 0);
    check("post_hs_busy", bus.o_busy, 0);
    tick();
    check("idle_busy", bus.o_busy, 0);
    check("idle_ro_en", bus.o_ro_en, 0);
  endtask

  task automatic run_abort();
    int nvalid;
    nvalid        = 0;
    bus.i_sel     = SEL_W'(3);
    bus.i_win_len = WIN_W'(40);
    bus.i_start   = 1'b1;
    bus.i_ro_clk  = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) bus.i_start = 1'b0;
      bus.i_ro_clk = ro_val(1, k, 3);
    end
    check("pre_abort_busy", bus.o_busy, 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("abort_ro_en", bus.o_ro_en, 0);
    check("abort_busy", bus.o_busy, 0);
    check("abort_valid", bus.o_cnt_valid, 0);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.o_cnt_valid || bus4.o_cnt_valid || bus.o_busy) nvalid++;
    end
    check("abort_no_result", nvalid, 0);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check("idle_abort_beats_start", bus.o_busy, 0);
    run_meas(0, 8, 2, 0);
  endtask

  task automatic run_reset_mid();
    bus.i_sel     = SEL_W'(2);
    bus.i_win_len = WIN_W'(20);
    bus.i_start   = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_ro_en", bus.o_ro_en, 0);
    check("rst_valid", bus.o_cnt_valid, 0);
    check("rst_cnt", bus.o_cnt, 0);
    check("rst_sat", bus.o_cnt_sat, 0);
    tick();
    check("rst_stays_idle", bus.o_busy, 0);
    run_meas(5, 20, 0, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_sel       = '0;
    bus.i_win_len   = '0;
    bus.i_ro_clk    = '0;
    bus.i_cnt_ready = 1'b0;
    repeat (3) tick();
    check("reset_busy", bus.o_busy, 0);
    check("reset_ro_en", bus.o_ro_en, 0);
    check("reset_valid", bus.o_cnt_valid, 0);
    check("reset_cnt", bus.o_cnt, 0);
    check("reset_sat", bus.o_cnt_sat, 0);
    rst_n = 1'b1;
    tick();

    run_meas(3, 40, 1, 0);   // basic count: 10 edges
    run_meas(3, 40, 1, 7);   // backpressure with a start during RESULT
    run_meas(3, 80, 1, 0);   // 20 edges: narrow counter saturates
    run_meas(4, 0, 0, 0);    // zero window
    run_abort();
    run_reset_mid();
    for (int i = 0; i < 12; i++)
      run_meas(int'($urandom_range(0, N_BITS - 1)), int'($urandom_range(0, 60)), 0,
               int'($urandom_range(0, 5)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/kudelski_ro_meas_ctrl.md
Name: kudelski_ro_meas_ctrl

Overview:
Measurement controller for the Kudelski ring-oscillator array. It sequences the shared RO enable and selects one RO output bit. It counts that bit's rising edges over a programmable window of system clocks and returns the count over a valid/ready interface. It sits between the RO wrapper (drives its i_en, consumes its o_ro_clk bus) and the CSR/test logic that requests measurements.

Parameters:
N_BITS, 8, number of ring-oscillator bits on i_ro_clk
CNT_W, 16, edge-counter / result width
WIN_W, 16, measurement-window length width (system clocks)
SETTLE_CYCLES, 4, cycles RO is enabled before counting starts (>=3, covers sync flush)
SEL_W, $clog2(N_BITS), width of RO select (derived, not overridden)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_start  in  1  measurement request pulse; accepted only in IDLE
i_abort  in  1  cancel measurement; no result produced
i_sel  in  SEL_W  RO bit to measure; sampled on accepted i_start
i_win_len  in  WIN_W  window length in cycles; sampled on accepted i_start
o_busy  out  1  high in any state except IDLE
o_ro_en  out  1  registered enable to RO wrapper i_en
i_ro_clk  in  N_BITS  asynchronous RO outputs from wrapper
o_cnt_valid  out  1  result valid
i_cnt_ready  in  1  result consumer ready
o_cnt  out  CNT_W  rising-edge count
o_cnt_sat  out  1  counter saturated during window

Behaviour:
- Reset (i_rst_n=0 at clock edge): state IDLE; o_busy=0, o_ro_en=0, o_cnt_valid=0, o_cnt=0, o_cnt_sat=0; all sync/edge flops and counters cleared. Reset mid-measurement behaves identically; there is no pending result.
- Input path: i_ro_clk[sel_q] selected by latched sel_q, then 2-flop synchronizer, then a third flop for edge detect. edge = sync & ~prev. Sync chain runs continuously in all states.
- FSM states: IDLE, SETTLE, MEASURE, RESULT.
- IDLE: i_start=1 latches sel_q, win_q, clears count/sat, goes to SETTLE. o_ro_en=1 and o_busy=1 from the next cycle.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to MEASURE. If win_q==0, goes directly to RESULT with o_cnt=0.
- MEASURE: lasts exactly win_q cycles. Each cycle with edge=1 increments the count. At all-ones the count holds and sat is set sticky. After the last cycle, go to RESULT.
- RESULT: o_ro_en=0, o_cnt_valid=1. o_cnt and o_cnt_sat are stable while valid. On o_cnt_valid & i_cnt_ready, go to IDLE; valid drops the next cycle. Edges arriving in RESULT are not counted.
- Back-to-back: i_start is ignored in every state except IDLE. A new start is accepted no earlier than the cycle after the handshake.
- i_abort=1 in SETTLE/MEASURE/RESULT: go to IDLE next cycle. Clears o_ro_en, o_cnt_valid, o_busy; o_cnt is held but meaningless. Abort takes priority over every other transition. In IDLE, abort has priority over a simultaneous start, so the start is dropped.
- i_sel/i_win_len changes after acceptance have no effect.
- Out-of-range i_sel (>= N_BITS, non-power-of-2 N_BITS) selects bit 0.
- Latency from accepted start to o_cnt_valid: 1 + SETTLE_CYCLES + win_q cycles (win_q>0). Assertions: o_cnt stable while valid & !ready; o_ro_en=0 whenever state IDLE/RESULT.

Test Plan:
- Basic count: sel=3, win_len=40, defaults. Bench holds i_ro_clk[3]=0 through SETTLE, then from the first MEASURE cycle toggles it with period 4 (2 high/2 low, rising first). Required: o_cnt=10, o_cnt_sat=0, valid exactly 45 cycles after the start cycle, o_ro_en high for cycles 1..44.
- Backpressure: same as above, with i_cnt_ready low for 7 cycles after valid. Required: o_cnt=10 held stable, o_busy=1 throughout, IDLE the cycle after ready. A start issued during RESULT is ignored.
- Saturation: CNT_W=4, win_len=80, period-4 toggling. Required: o_cnt=15, o_cnt_sat=1.
- Zero window: win_len=0. Required: valid at start+1+SETTLE_CYCLES (cycle 5), o_cnt=0, no counting.
- Abort: abort in MEASURE cycle 10 of a 40-cycle window. Required: next cycle o_ro_en=0, o_busy=0, no o_cnt_valid ever asserts. A subsequent start with sel=0, win_len=8 and constant-0 input returns o_cnt=0.
- Reset mid-op: i_rst_n=0 for one clock during SETTLE. Required: all outputs 0 on the following cycle, state IDLE, and a new measurement runs normally.
